// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: Moore FSM plus ALU and immediate decoders.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes park in TRAP until reset).
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        adr_src,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_control,
  output logic [3:0]  state,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] w_op;
  logic [2:0] w_funct3;
  logic       w_funct7b5;
  logic       w_pc_update;
  logic       w_branch;
  logic [1:0] w_alu_op;
  logic [1:0] w_imm;
  logic       w_unused_instr;

  assign w_op           = instr[6:0];
  assign w_funct3       = instr[14:12];
  assign w_funct7b5     = instr[30];
  assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // State register; reset aborts any access in flight and restarts fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; mem_ready only matters in the three memory-wait states.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = w_op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_BEQ:      w_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`else
      S_TRAP:     w_next = S_FETCH;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  // Per-state control decode; FETCH strobes wait for the instruction to arrive.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_alu_op    = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write    = 1'b1;
          w_pc_update = 1'b1;
          alu_src_b   = 2'b10;
          result_src  = 2'b10;
        end else begin
          ir_write    = 1'b0;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        w_alu_op  = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_alu_op  = 2'b10;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        w_alu_op  = 2'b01;
        w_branch  = 1'b1;
      end
      default: mem_req = 1'b0;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    w_imm = 2'b00;
    case (w_op)
      OP_SW:   w_imm = 2'b01;
      OP_BEQ:  w_imm = 2'b10;
      OP_JAL:  w_imm = 2'b11;
      default: w_imm = 2'b00;
    endcase
  end

  // ALU function select; only R-type (op[5]=1) turns funct7b5 into a subtract.
  always_comb begin
    alu_control = 3'b000;
    case (w_alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (w_funct3)
          3'b000:  alu_control = (w_op[5] & w_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  assign imm_src  = (r_state == S_TRAP) ? 2'b00 : w_imm;
  assign pc_write = w_pc_update | (w_branch & zero);
  assign state    = r_state;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected cycle sequence, checked every negedge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, mwr, irw, pcw, rw, adr;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero, mem_ready;
  logic        mem_req, mem_write, ir_write, pc_write, reg_write, adr_src;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [3:0]  state;
  logic        illegal;

  int   n_chk = 0;
  int   n_err = 0;
  int   cnt_rw, cnt_mw, cnt_bpc;
  logic [2:0] alu_exec, alu_beq;
  logic [3:0] tr[$];
  exp_t exp_cur;
  logic r_chk = 1'b0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .adr_src(adr_src), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == 7'h23) return 2'b01;
    else if (op == 7'h63) return 2'b10;
    else if (op == 7'h6F) return 2'b11;
    else return 2'b00;
  endfunction

  // Arithmetic-op select from the instruction fields for EXECR/EXECI.
  function automatic logic [2:0] fn_alu(input logic [31:0] iv);
    case (iv[14:12])
      3'd0:    return (iv[5] && iv[30]) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic exp_t ex(input logic [3:0] st, input logic mreq, input logic mwr,
                              input logic irw, input logic pcw, input logic rw, input logic adr,
                              input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [2:0] alu);
    exp_t e;
    e = '{st: st, mreq: mreq, mwr: mwr, irw: irw, pcw: pcw, rw: rw, adr: adr,
          rs: rs, sa: sa, sb: sb, imm: imm_of(instr[6:0]), alu: alu, ill: 1'b0};
    return e;
  endfunction

  function automatic exp_t fexp(input logic rdy);
    return ex(4'd0, 1'b1, 1'b0, rdy, rdy, 1'b0, 1'b0, rdy ? 2'b10 : 2'b00, 2'b00,
              rdy ? 2'b10 : 2'b00, 3'd0);
  endfunction

  // Per-cycle compare against the model plus counters used by the literal checks.
  always @(negedge clk) begin
    if (reg_write) cnt_rw++;
    if (mem_write) cnt_mw++;
    if (state == 4'd10 && pc_write) cnt_bpc++;
    if (state == 4'd6 || state == 4'd8) alu_exec = alu_control;
    if (state == 4'd10) alu_beq = alu_control;
    if (r_chk) begin
      tr.push_back(state);
      check("cycle", {state, mem_req, mem_write, ir_write, pc_write, reg_write, adr_src,
                      result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal},
            exp_cur);
    end
  end

  task automatic step(input exp_t e);
    exp_cur = e;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cnt_rw = 0; cnt_mw = 0; cnt_bpc = 0;
    alu_exec = 3'bx; alu_beq = 3'bx;
    tr.delete();
  endtask

  // Expand one instruction into its expected cycles, with fw/mw ready-low stalls.
  task automatic run(input logic [31:0] iv, input logic zv, input int fw, input int mw);
    exp_t e;
    instr = iv; zero = zv;
    for (int i = 0; i < fw; i++) begin mem_ready = 1'b0; step(fexp(1'b0)); end
    mem_ready = 1'b1; step(fexp(1'b1));
    step(ex(4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0));
    case (iv[6:0])
      7'h03, 7'h23: begin
        step(ex(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0));
        if (iv[5]) e = ex(4'd5, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0);
        else       e = ex(4'd3, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0);
        for (int i = 0; i < mw; i++) begin mem_ready = 1'b0; step(e); end
        mem_ready = 1'b1; step(e);
        if (!iv[5]) step(ex(4'd4, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3'd0));
      end
      7'h33, 7'h13: begin
        step(ex(iv[5] ? 4'd6 : 4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                iv[5] ? 2'b00 : 2'b01, fn_alu(iv)));
        step(ex(4'd7, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'd0));
      end
      7'h6F: begin
        step(ex(4'd9, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0));
        step(ex(4'd7, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'd0));
      end
      7'h63: step(ex(4'd10, 0, 0, 0, zv, 0, 0, 2'b00, 2'b10, 2'b00, 3'd1));
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        e = '{st: 4'd11, ill: 1'b1, default: '0};
        for (int i = 0; i < 4; i++) begin mem_ready = i[0]; step(e); end
`endif
      end
    endcase
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    clr();
    #2;
    check("reset_state", state, 4'd0);
    check("reset_illegal", illegal, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    exp_cur = fexp(1'b0);
    r_chk = 1'b1;
    @(posedge clk); #1;

    clr(); run(32'h00402083, 1'b0, 0, 0);
    check("lw_trace_len", tr.size(), 5);
    if (tr.size() >= 5)
      check("lw_trace", {tr[0], tr[1], tr[2], tr[3], tr[4]}, 20'h01234);
    check("lw_regwrite_cnt", cnt_rw, 1);

    clr(); run(32'h00202423, 1'b0, 2, 3);
    check("sw_memwrite_cnt", cnt_mw, 4);
    check("sw_regwrite_cnt", cnt_rw, 0);

    clr(); run(32'h00000063, 1'b1, 0, 0);
    check("beq_taken_pulses", cnt_bpc, 1);
    check("beq_alu", alu_beq, 3'b001);
    clr(); run(32'h00000063, 1'b0, 1, 0);
    check("beq_nt_pulses", cnt_bpc, 0);

    clr(); run(32'h402081B3, 1'b0, 0, 0);
    check("sub_alu", alu_exec, 3'b001);
    clr(); run(32'h40208193, 1'b0, 0, 0);
    check("addi_f7_alu", alu_exec, 3'b000);
    clr(); run(32'h0020A1B3, 1'b0, 0, 0);
    check("slt_alu", alu_exec, 3'b101);
    run(32'h0020E193, 1'b1, 0, 0);
    run(32'h0020F1B3, 1'b0, 0, 0);
    clr(); run(32'h0000006F, 1'b0, 0, 0);
    check("jal_regwrite_cnt", cnt_rw, 1);

    clr(); run(32'hFFFFFFFF, 1'b0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("trap_held", {state, illegal}, {4'd11, 1'b1});
    r_chk = 1'b0;
    rst_n = 1'b0; #1;
    check("trap_reset", {state, illegal}, {4'd0, 1'b0});
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    r_chk = 1'b1;
`else
    mem_ready = 1'b0; step(fexp(1'b0));
    check("illegal_nop", {state, illegal}, {4'd0, 1'b0});
`endif

    // Reset while MEMREAD is stalled must abort without any register write.
    clr();
    instr = 32'h00402083; zero = 1'b0;
    mem_ready = 1'b1; step(fexp(1'b1));
    step(ex(4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0));
    step(ex(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0));
    mem_ready = 1'b0;
    step(ex(4'd3, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0));
    r_chk = 1'b0;
    #2; rst_n = 1'b0; #1;
    check("abort_state", state, 4'd0);
    check("abort_regwrite", reg_write, 1'b0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("abort_hold", state, 4'd0);
    mem_ready = 1'b0;
    #2; rst_n = 1'b1;
    exp_cur = fexp(1'b0);
    r_chk = 1'b1;
    @(posedge clk); #1;
    step(fexp(1'b0));
    check("abort_regwrite_cnt", cnt_rw, 0);
    run(32'h00402083, 1'b0, 1, 1);
    check("restart_regwrite_cnt", cnt_rw, 1);

    r_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
